// File: rtl/drop_bounce_ctl.sv
// Drop-and-bounce position controller: the object follows the mouse, falls under integer
// gravity on a left release, rebounds off FLOOR_Y with percentage restitution, re-arms on right.
module drop_bounce_ctl #(
   parameter int POS_W       = 12,
   parameter int FLOOR_Y     = 536,
   parameter int TICK_DIV    = 1000000,
   parameter int ACCEL_STEPS = 13,
   parameter int V_W         = 16,
   parameter int REST_PCT    = 80,
   parameter int MIN_SPEED   = 2,
   parameter bit FREEZE_X    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [POS_W-1:0] mouse_xpos,
   input  logic [POS_W-1:0] mouse_ypos,
   input  logic             mouse_left,
   input  logic             mouse_right,
   output logic [POS_W-1:0] xpos,
   output logic [POS_W-1:0] ypos,
   output logic [1:0]       state,
   output logic [3:0]       bounce_cnt
);

   localparam int ACC_W = $clog2(TICK_DIV + (2 ** V_W) + 1);
   localparam int SC_W  = (ACCEL_STEPS > 1) ? $clog2(ACCEL_STEPS) : 1;
   localparam int PW    = V_W + 7;
   localparam logic [POS_W-1:0] FLOOR     = POS_W'(FLOOR_Y);
   localparam logic [ACC_W-1:0] TICK      = ACC_W'(TICK_DIV);
   localparam logic [SC_W-1:0]  STEP_LAST = SC_W'(ACCEL_STEPS - 1);
   localparam logic [V_W-1:0]   V_MIN     = V_W'(MIN_SPEED);

   typedef enum logic [1:0] {
      FOLLOW = 2'b00,
      FALL   = 2'b01,
      RISE   = 2'b10,
      REST   = 2'b11
   } st_e;

   st_e              st_q, st_n;
   logic [POS_W-1:0] xpos_n, ypos_n;
   logic [V_W-1:0]   v, v_n;
   logic [ACC_W-1:0] acc, acc_n;
   logic [SC_W-1:0]  step_cnt, step_n;
   logic [3:0]       bcnt_n;
   logic             left_prv;

   logic             release_ev;
   logic [PW-1:0]    prod;
   logic [V_W-1:0]   v_bounce;
   logic [V_W-1:0]   v_sat_inc;

   assign release_ev = left_prv & ~mouse_left;
   assign prod       = PW'(v) * PW'(REST_PCT);
   assign v_bounce   = V_W'(prod / PW'(100));
   assign v_sat_inc  = (&v) ? v : v + 1'b1;
   assign state      = st_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q       <= FOLLOW;
         xpos       <= '0;
         ypos       <= '0;
         v          <= '0;
         acc        <= '0;
         step_cnt   <= '0;
         bounce_cnt <= '0;
         left_prv   <= 1'b0;
      end else begin
         st_q       <= st_n;
         xpos       <= xpos_n;
         ypos       <= ypos_n;
         v          <= v_n;
         acc        <= acc_n;
         step_cnt   <= step_n;
         bounce_cnt <= bcnt_n;
         left_prv   <= mouse_left;
      end
   end

   always_comb begin
      st_n   = st_q;
      xpos_n = (st_q == FOLLOW || !FREEZE_X) ? mouse_xpos : xpos;
      ypos_n = ypos;
      v_n    = v;
      acc_n  = acc;
      step_n = step_cnt;
      bcnt_n = bounce_cnt;

      // Re-arm wins over everything, including a release in the same cycle.
      if (mouse_right) begin
         st_n   = FOLLOW;
         v_n    = '0;
         acc_n  = '0;
         step_n = '0;
         bcnt_n = '0;
      end else begin
         unique case (st_q)
            FOLLOW: begin
               if (release_ev) begin
                  st_n   = FALL;
                  v_n    = '0;
                  acc_n  = '0;
                  step_n = '0;
                  bcnt_n = '0;
               end else begin
                  ypos_n = (mouse_ypos > FLOOR) ? FLOOR : mouse_ypos;
               end
            end
            FALL: begin
               if (ypos == FLOOR) begin
                  v_n    = v_bounce;
                  acc_n  = '0;
                  step_n = '0;
                  bcnt_n = (&bounce_cnt) ? bounce_cnt : bounce_cnt + 4'd1;
                  st_n   = (v_bounce < V_MIN) ? REST : RISE;
               end else if (acc >= TICK) begin
                  ypos_n = ypos + 1'b1;
                  acc_n  = '0;
                  if (step_cnt == STEP_LAST) begin
                     step_n = '0;
                     v_n    = v_sat_inc;
                  end else begin
                     step_n = step_cnt + 1'b1;
                  end
               end else begin
                  acc_n = acc + ACC_W'(v) + ACC_W'(1);
               end
            end
            RISE: begin
               if (v == '0) begin
                  st_n   = FALL;
                  acc_n  = '0;
                  step_n = '0;
               end else if (acc >= TICK) begin
                  acc_n = '0;
                  // Ceiling clamp: turn around at row 0 instead of wrapping.
                  if (ypos == '0) begin
                     st_n = FALL;
                  end else begin
                     ypos_n = ypos - 1'b1;
                     if (step_cnt == STEP_LAST) begin
                        step_n = '0;
                        v_n    = v - 1'b1;
                     end else begin
                        step_n = step_cnt + 1'b1;
                     end
                  end
               end else begin
                  acc_n = acc + ACC_W'(v);
               end
            end
            REST: begin
               ypos_n = FLOOR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_drop_bounce_ctl.sv
// Directed bench for drop_bounce_ctl: follow/clamp, drop timing, bounces, re-arm,
// asynchronous reset mid-drop and the ceiling clamp on a large rebound.
module tb_drop_bounce_ctl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] mx = '0, my = '0;
   logic        ml = 1'b0, mr = 1'b0;
   logic [11:0] xpos, ypos;
   logic [1:0]  state;
   logic [3:0]  bcnt;

   logic [11:0] mx2 = '0, my2 = '0;
   logic        ml2 = 1'b0, mr2 = 1'b0;
   logic [11:0] xpos2, ypos2;
   logic [1:0]  state2;
   logic [3:0]  bcnt2;

   int n_chk = 0;
   int n_bad = 0;
   int cyc   = 0;
   logic [25:0] exp_q[$];

   drop_bounce_ctl #(
      .POS_W(12), .FLOOR_Y(20), .TICK_DIV(4), .ACCEL_STEPS(2), .V_W(8),
      .REST_PCT(50), .MIN_SPEED(1), .FREEZE_X(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .mouse_xpos(mx), .mouse_ypos(my),
      .mouse_left(ml), .mouse_right(mr), .xpos(xpos), .ypos(ypos),
      .state(state), .bounce_cnt(bcnt)
   );

   drop_bounce_ctl #(
      .POS_W(12), .FLOOR_Y(20), .TICK_DIV(1), .ACCEL_STEPS(100), .V_W(8),
      .REST_PCT(100), .MIN_SPEED(1), .FREEZE_X(1'b0)
   ) dut2 (
      .clk(clk), .rst(rst), .mouse_xpos(mx2), .mouse_ypos(my2),
      .mouse_left(ml2), .mouse_right(mr2), .xpos(xpos2), .ypos(ypos2),
      .state(state2), .bounce_cnt(bcnt2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic advance_to(input int k);
      while (cyc < k) tick();
   endtask

   task automatic cp(input int k, input int y, input int s, input int b);
      exp_q.push_back({8'(k), 12'(y), 2'(s), 4'(b)});
   endtask

   initial begin
      logic [25:0] e;
      bit          wrapped;

      // Power-up reset
      mx = 12'd7; my = 12'd30; mx2 = 12'd4; my2 = 12'd18;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_y", ypos, 0); chk("rst_x", xpos, 0);
      chk("rst_st", state, 0); chk("rst_b", bcnt, 0);
      rst = 1'b1;

      // Follow with clamp and one-cycle latency
      chk("lat_y", ypos, 0);
      tick();
      chk("clamp_y", ypos, 20); chk("clamp_x", xpos, 7); chk("clamp_st", state, 0);
      my = 12'd10;
      tick();
      chk("follow_y", ypos, 10);

      // Drop from row 10; cycle k counts edges after the left release
      ml = 1'b1;
      tick();
      ml = 1'b0;
      cyc = 0;
      cp(1,10,1,0);  cp(5,10,1,0);  cp(6,11,1,0);  cp(10,11,1,0); cp(11,12,1,0);
      cp(13,12,1,0); cp(14,13,1,0); cp(17,14,1,0); cp(20,15,1,0); cp(23,16,1,0);
      cp(25,17,1,0); cp(27,18,1,0); cp(29,19,1,0); cp(31,20,1,0); cp(32,20,2,1);
      cp(34,20,2,1); cp(35,19,2,1); cp(38,18,2,1); cp(42,18,2,1); cp(43,17,2,1);
      cp(48,16,2,1); cp(49,16,1,1); cp(53,16,1,1); cp(54,17,1,1); cp(59,18,1,1);
      cp(62,19,1,1); cp(65,20,1,1); cp(66,20,2,2); cp(70,20,2,2); cp(71,19,2,2);
      cp(76,18,2,2); cp(77,18,1,2); cp(82,19,1,2); cp(86,19,1,2); cp(87,20,1,2);
      cp(88,20,3,3); cp(95,20,3,3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         advance_to(int'(e[25:18]));
         chk($sformatf("drop%0d_y", cyc), ypos, e[17:6]);
         chk($sformatf("drop%0d_st", cyc), state, e[5:4]);
         chk($sformatf("drop%0d_b", cyc), bcnt, e[3:0]);
         chk($sformatf("drop%0d_x", cyc), xpos, 7);
         if (cyc == 1) mx = 12'd99;
      end

      // Release in REST is ignored
      my = 12'd5;
      ml = 1'b1; tick();
      ml = 1'b0; tick();
      chk("rest_rel_st", state, 3); chk("rest_rel_y", ypos, 20);

      // Right and release together: right wins
      ml = 1'b1; tick();
      ml = 1'b0; mr = 1'b1; tick();
      chk("rearm_st", state, 0); chk("rearm_b", bcnt, 0);
      mr = 1'b0; tick();
      chk("rearm_y", ypos, 5); chk("rearm_x", xpos, 99); chk("rearm_st2", state, 0);

      // Asynchronous reset mid-fall at row 12
      my = 12'd10; tick();
      ml = 1'b1; tick();
      ml = 1'b0;
      cyc = 0;
      advance_to(11);
      chk("pre_rst_y", ypos, 12); chk("pre_rst_st", state, 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_y", ypos, 0); chk("arst_x", xpos, 0);
      chk("arst_st", state, 0); chk("arst_b", bcnt, 0);
      tick();
      chk("arst_hold_y", ypos, 0);
      rst = 1'b1;
      tick();
      chk("post_rst_st", state, 0); chk("post_rst_y", ypos, 10);

      // Ceiling clamp on a 200 px/step rebound (second instance, x tracks mouse)
      ml2 = 1'b1; tick();
      ml2 = 1'b0;
      cyc = 0;
      advance_to(1);
      chk("c_entry_st", state2, 1);
      force dut2.v = 8'd200;
      advance_to(3);
      chk("c_fall_y", ypos2, 19);
      advance_to(5);
      chk("c_floor_y", ypos2, 20);
      advance_to(6);
      chk("c_bounce_st", state2, 2); chk("c_bounce_b", bcnt2, 1); chk("c_bounce_y", ypos2, 20);
      release dut2.v;
      mx2 = 12'd33;
      wrapped = 1'b0;
      while (cyc < 48) begin
         tick();
         if (ypos2 > 12'd20) wrapped = 1'b1;
         if (cyc == 8) begin
            chk("c_rise_y", ypos2, 19); chk("c_track_x", xpos2, 33);
         end
         if (cyc == 46) begin
            chk("c_top_y", ypos2, 0); chk("c_top_st", state2, 2);
         end
         if (cyc == 47) chk("c_top2_y", ypos2, 0);
      end
      chk("c_nowrap", {31'd0, wrapped}, 0);
      chk("c_turn_st", state2, 1); chk("c_turn_y", ypos2, 0);
      advance_to(50);
      chk("c_refall_y", ypos2, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
